bankgroup_rd_collector: RTL and testbench

- Sits directly downstream of the bank group and consumes its `dout` bus. That bus is `C_L_bus` = 33 bits: bit 32 is the read-valid flag, bits 31:0 are the data.
- Matches each returned read word to the tag recorded when the read was issued, and buffers tagged words in a response FIFO drained over a valid/ready handshake.
- Issues read credits upstream so returned data is never dropped.

---
 rtl/bankgroup_rd_collector_pkg.sv | 21 ++
 rtl/bankgroup_rd_collector_sync_fifo.sv | 73 +++++++
 rtl/bankgroup_rd_collector.sv | 106 ++++++++++
 tb/tb_bankgroup_rd_collector.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bankgroup_rd_collector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | bankgroup_rd_collector_pkg : bus geometry and defaults shared by the collector
// | Rev 1.0
// +----------------------------------------------------------------------------
package bankgroup_rd_collector_pkg;

  // The bank group output bus is one valid flag on top of the data word.
  localparam int C_L_BUS_W   = 33;
  localparam int C_VALID_BIT = C_L_BUS_W - 1;
  localparam int C_L_DW      = C_VALID_BIT;
  localparam int DEPTH_DEF   = 4;
  localparam int TAG_W_DEF   = 2;

  // One extra bit over the pointer width so that full and empty differ.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bankgroup_rd_collector_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | bankgroup_rd_collector_sync_fifo : show-ahead synchronous FIFO with flush
// | Rev 1.0
// +----------------------------------------------------------------------------
module bankgroup_rd_collector_sync_fifo
  import bankgroup_rd_collector_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Head is forced to zero while empty so reset/flush present a clean bus.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/bankgroup_rd_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | bankgroup_rd_collector : tags bank group read returns and buffers them
// | Rev 1.0
// +----------------------------------------------------------------------------
module bankgroup_rd_collector
  import bankgroup_rd_collector_pkg::*;
#(
  parameter int DW    = C_L_DW,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TAG_W = TAG_W_DEF,
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             rd_issue,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic [DW:0]      bg_dout,
  output logic             rd_credit,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CW-1:0]    outstanding,
  output logic             err_ovf,
  output logic             err_unexp
);

  logic                ret_valid;
  logic                tag_push, tag_pop, rsp_push, rsp_pop;
  logic [TAG_W-1:0]    tag_head;
  logic [CW-1:0]       tag_count, rsp_count;
  logic                tag_full, tag_empty, rsp_full, rsp_empty;
  logic [TAG_W+DW-1:0] rsp_wdata, rsp_rdata;
  logic [CW:0]         inflight;
  logic                err_ovf_q, err_ovf_d, err_unexp_q, err_unexp_d;

  assign ret_valid = bg_dout[DW];

  // Credit depends only on registered occupancy, never on this cycle's inputs.
  assign inflight  = {1'b0, tag_count} + {1'b0, rsp_count};
  assign rd_credit = (inflight < (CW+1)'(DEPTH));

  assign tag_push  = rd_issue & rd_credit & ~flush;
  assign tag_pop   = ret_valid & ~tag_empty & ~flush;
  assign rsp_push  = tag_pop;
  assign rsp_pop   = rsp_valid & rsp_ready & ~flush;
  assign rsp_wdata = {tag_head, bg_dout[DW-1:0]};

  bankgroup_rd_collector_sync_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (tag_push),
    .pop_i   (tag_pop),
    .wdata_i (rd_tag),
    .rdata_o (tag_head),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  bankgroup_rd_collector_sync_fifo #(.WIDTH(TAG_W+DW), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (rsp_push),
    .pop_i   (rsp_pop),
    .wdata_i (rsp_wdata),
    .rdata_o (rsp_rdata),
    .count_o (rsp_count),
    .full_o  (rsp_full),
    .empty_o (rsp_empty)
  );

  always_comb begin
    err_ovf_d   = err_ovf_q;
    err_unexp_d = err_unexp_q;
    if (!flush && rd_issue && !rd_credit) err_ovf_d   = 1'b1;
    if (!flush && ret_valid && tag_empty) err_unexp_d = 1'b1;
  end

  // Error flags are sticky across flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q   <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      err_ovf_q   <= err_ovf_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  assign rsp_valid   = ~rsp_empty;
  assign rsp_data    = rsp_rdata[DW-1:0];
  assign rsp_tag     = rsp_rdata[TAG_W+DW-1:DW];
  assign outstanding = tag_count;
  assign err_ovf     = err_ovf_q;
  assign err_unexp   = err_unexp_q;

  a_rsp_no_overflow: assert property (@(posedge clk) disable iff (rst) !(rsp_push && rsp_full));
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst) !(tag_push && tag_full));

endmodule
`default_nettype wire

// File: tb/tb_bankgroup_rd_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_bankgroup_rd_collector : randomized scoreboard bench for the collector
// | Rev 1.0
// +----------------------------------------------------------------------------
module tb_bankgroup_rd_collector;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst, flush, rd_issue, rsp_ready;
  logic [TAG_W-1:0] rd_tag;
  logic [DW:0]      bg_dout;
  logic             rd_credit, rsp_valid, err_ovf, err_unexp;
  logic [DW-1:0]    rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [CW-1:0]    outstanding;

  always #5 clk = ~clk;

  bankgroup_rd_collector #(.DW(DW), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .rd_issue    (rd_issue),
    .rd_tag      (rd_tag),
    .bg_dout     (bg_dout),
    .rd_credit   (rd_credit),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_tag     (rsp_tag),
    .outstanding (outstanding),
    .err_ovf     (err_ovf),
    .err_unexp   (err_unexp)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: tags in flight, buffered response count, sticky errors.
  logic [TAG_W-1:0]    m_tags[$];
  int                  m_rsp;
  bit                  m_ovf, m_unexp;
  logic [TAG_W+DW-1:0] sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("rd_credit", 64'(rd_credit), 64'((m_tags.size() + m_rsp) < DEPTH));
    chk("outstanding", 64'(outstanding), 64'(m_tags.size()));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp > 0));
    chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
    chk("err_unexp", 64'(err_unexp), 64'(m_unexp));
  endtask

  task automatic step(input bit iss, input logic [TAG_W-1:0] tg, input bit rv,
                      input logic [DW-1:0] d, input bit rdy, input bit fl);
    bit credit;
    check_state();
    rd_issue  = iss;
    rd_tag    = tg;
    bg_dout   = {rv, d};
    rsp_ready = rdy;
    flush     = fl;
    if (fl) begin
      m_tags.delete();
      m_rsp = 0;
      sb.delete();
    end else begin
      credit = (m_tags.size() + m_rsp) < DEPTH;
      if (rdy && m_rsp > 0) m_rsp--;
      if (rv) begin
        if (m_tags.size() > 0) begin
          sb.push_back({m_tags.pop_front(), d});
          m_rsp++;
        end else begin
          m_unexp = 1'b1;
        end
      end
      if (iss) begin
        if (credit) m_tags.push_back(tg);
        else        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 32'hFFFF_FFFF, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; rd_issue = 1'b0; rd_tag = '0;
    rsp_ready = 1'b0; bg_dout = {1'b0, 32'hFFFF_FFFF};
    m_tags.delete(); m_rsp = 0; m_ovf = 1'b0; m_unexp = 1'b0; sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_state();
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
  endtask

  // Monitor: head must match the oldest expected response; pops on handshake.
  always @(negedge clk) begin
    if (rst === 1'b0 && flush === 1'b0 && rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_spurious: got tag %0h data %0h expected no response at %0t",
                 rsp_tag, rsp_data, $time);
      end else begin
        chk("rsp_tag", 64'(rsp_tag), 64'(sb[0][TAG_W+DW-1:DW]));
        chk("rsp_data", 64'(rsp_data), 64'(sb[0][DW-1:0]));
        if (rsp_ready === 1'b1) void'(sb.pop_front());
      end
    end
  end

  initial begin
    do_reset();

    // Single read, tag 2.
    step(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step(1'b0, 2'd0, 1'b1, 32'h0000_00A5, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Credit exhaustion with consumer stalled, then one pop frees one credit.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    idle(5, 1'b1);

    // Overflow: issue with no credit; flag survives flush, clears on reset.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    idle(2, 1'b1);
    do_reset();

    // Unexpected return with nothing outstanding.
    step(1'b0, 2'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    idle(2, 1'b1);
    do_reset();

    // Idle bus carrying all ones.
    idle(10, 1'b1);

    // Same-cycle issue and return: return belongs to the older tag.
    step(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b1, 32'h0000_0011, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 32'h0000_0022, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Flush with 2 outstanding, 1 buffered, and a colliding return.
    for (int i = 0; i < 3; i++) step(1'b1, 2'(i), 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 32'h0000_0AAA, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 32'h0000_0BAD, 1'b1, 1'b1);
    idle(4, 1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom), 2'($urandom), 1'($urandom), $urandom,
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
      end
    end

    idle(10, 1'b1);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
